// File: rtl/alu_unit_pkg.sv
// Shared opcode encodings and default widths for the integer execution stage.
package alu_unit_pkg;

  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam int ROB_LEN  = 4;
  localparam int OP_LEN   = 6;

  // Any encoding not listed here is treated as a no-op: val=0, no redirect.
  localparam logic [OP_LEN-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_LEN-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_LEN-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_LEN-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_LEN-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_LEN-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_LEN-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_LEN-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_LEN-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_LEN-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_LEN-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_LEN-1:0] OP_ADD   = 6'd11;
  localparam logic [OP_LEN-1:0] OP_SUB   = 6'd12;
  localparam logic [OP_LEN-1:0] OP_SLL   = 6'd13;
  localparam logic [OP_LEN-1:0] OP_SLT   = 6'd14;
  localparam logic [OP_LEN-1:0] OP_SLTU  = 6'd15;
  localparam logic [OP_LEN-1:0] OP_XOR   = 6'd16;
  localparam logic [OP_LEN-1:0] OP_SRL   = 6'd17;
  localparam logic [OP_LEN-1:0] OP_SRA   = 6'd18;
  localparam logic [OP_LEN-1:0] OP_OR    = 6'd19;
  localparam logic [OP_LEN-1:0] OP_AND   = 6'd20;
  localparam logic [OP_LEN-1:0] OP_ADDI  = 6'd21;
  localparam logic [OP_LEN-1:0] OP_SLTI  = 6'd22;
  localparam logic [OP_LEN-1:0] OP_SLTIU = 6'd23;
  localparam logic [OP_LEN-1:0] OP_XORI  = 6'd24;
  localparam logic [OP_LEN-1:0] OP_ORI   = 6'd25;
  localparam logic [OP_LEN-1:0] OP_ANDI  = 6'd26;
  localparam logic [OP_LEN-1:0] OP_SLLI  = 6'd27;
  localparam logic [OP_LEN-1:0] OP_SRLI  = 6'd28;
  localparam logic [OP_LEN-1:0] OP_SRAI  = 6'd29;

endpackage

// File: rtl/alu_unit_core.sv
// Combinational RV32I integer datapath: result value, redirect flag and actual next pc.
module alu_core
  import alu_unit_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int ADDR_W = ADDR_LEN,
  parameter int OP_W   = OP_LEN
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] vj,
  input  logic [DATA_W-1:0] vk,
  output logic [DATA_W-1:0] val,
  output logic              jump,
  output logic [ADDR_W-1:0] target
);

  localparam int SH_W = $clog2(DATA_W);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] pc_imm;
  logic              cond;

  assign pc4    = pc + ADDR_W'(4);
  assign pc_imm = pc + ADDR_W'(imm);

  always_comb begin
    val    = '0;
    jump   = 1'b0;
    target = pc4;
    cond   = 1'b0;
    case (op)
      OP_ADD:   val = vj + vk;
      OP_SUB:   val = vj - vk;
      OP_AND:   val = vj & vk;
      OP_OR:    val = vj | vk;
      OP_XOR:   val = vj ^ vk;
      OP_SLL:   val = vj << vk[SH_W-1:0];
      OP_SRL:   val = vj >> vk[SH_W-1:0];
      OP_SRA:   val = $signed(vj) >>> vk[SH_W-1:0];
      OP_SLT:   val = DATA_W'($signed(vj) < $signed(vk));
      OP_SLTU:  val = DATA_W'(vj < vk);
      OP_ADDI:  val = vj + imm;
      OP_ANDI:  val = vj & imm;
      OP_ORI:   val = vj | imm;
      OP_XORI:  val = vj ^ imm;
      OP_SLLI:  val = vj << imm[SH_W-1:0];
      OP_SRLI:  val = vj >> imm[SH_W-1:0];
      OP_SRAI:  val = $signed(vj) >>> imm[SH_W-1:0];
      OP_SLTI:  val = DATA_W'($signed(vj) < $signed(imm));
      OP_SLTIU: val = DATA_W'(vj < imm);
      OP_LUI:   val = imm;
      OP_AUIPC: val = DATA_W'(pc_imm);
      OP_JAL: begin
        val    = DATA_W'(pc4);
        jump   = 1'b1;
        target = pc_imm;
      end
      OP_JALR: begin
        val    = DATA_W'(pc4);
        jump   = 1'b1;
        target = ADDR_W'(vj + imm) & ~ADDR_W'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  cond = (vj == vk);
          OP_BNE:  cond = (vj != vk);
          OP_BLT:  cond = ($signed(vj) < $signed(vk));
          OP_BGE:  cond = ($signed(vj) >= $signed(vk));
          OP_BLTU: cond = (vj < vk);
          default: cond = (vj >= vk);
        endcase
        jump   = cond;
        target = cond ? pc_imm : pc4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// ALU execution stage: computes one op per cycle and queues results for the CDB slot.
// Handshake: an entry leaves the FIFO on a posedge where cdb_valid && cdb_grant && ready && !clear.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int ADDR_W = ADDR_LEN,
  parameter int ROB_W  = ROB_LEN,
  parameter int OP_W   = OP_LEN,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_robpos,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  output logic              alu_stall,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_robpos,
  output logic [DATA_W-1:0] cdb_val,
  output logic              cdb_jump,
  output logic [ADDR_W-1:0] cdb_target,
  input  logic              cdb_grant
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] core_val;
  logic              core_jump;
  logic [ADDR_W-1:0] core_target;

  alu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_core (
    .op     (in_op),
    .imm    (in_imm),
    .pc     (in_pc),
    .vj     (in_vj),
    .vk     (in_vk),
    .val    (core_val),
    .jump   (core_jump),
    .target (core_target)
  );

  logic [DATA_W-1:0] val_mem    [DEPTH];
  logic [ROB_W-1:0]  rob_mem    [DEPTH];
  logic              jump_mem   [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop, full, push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push    = in_valid && ready && !clear;
  assign pop     = cdb_valid && cdb_grant && ready && !clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      alu_stall <= 1'b0;
    end else if (ready) begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      count     <= count_next;
      alu_stall <= (count_next >= CNT_W'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      val_mem[tail]    <= core_val;
      rob_mem[tail]    <= in_robpos;
      jump_mem[tail]   <= core_jump;
      target_mem[tail] <= core_target;
    end
  end

  assign cdb_valid  = (count != '0);
  assign cdb_val    = cdb_valid ? val_mem[head]    : '0;
  assign cdb_robpos = cdb_valid ? rob_mem[head]    : '0;
  assign cdb_jump   = cdb_valid ? jump_mem[head]   : 1'b0;
  assign cdb_target = cdb_valid ? target_mem[head] : '0;

  always @(posedge clk) begin
    if (reset)
      assert (!(push && full && !pop))
        else $error("alu_unit: push into full result FIFO dropped");
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: datapath vectors, FIFO ordering, stall, flush, freeze and reset.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        clear;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [3:0]  in_robpos;
  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic        alu_stall;
  logic        cdb_valid;
  logic [3:0]  cdb_robpos;
  logic [31:0] cdb_val;
  logic        cdb_jump;
  logic [31:0] cdb_target;
  logic        cdb_grant;

  int n_pass;
  int n_total;

  alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_robpos  (in_robpos),
    .in_vj      (in_vj),
    .in_vk      (in_vk),
    .alu_stall  (alu_stall),
    .cdb_valid  (cdb_valid),
    .cdb_robpos (cdb_robpos),
    .cdb_val    (cdb_val),
    .cdb_jump   (cdb_jump),
    .cdb_target (cdb_target),
    .cdb_grant  (cdb_grant)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk);
    in_op     = op;
    in_imm    = imm;
    in_pc     = pc;
    in_robpos = rob;
    in_vj     = vj;
    in_vk     = vk;
    in_valid  = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk);
    drive_op(op, imm, pc, rob, vj, vk);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] val, input logic jump,
                          input logic [31:0] target);
    chk({tag, ".valid"},  {31'd0, cdb_valid}, 32'd1);
    chk({tag, ".val"},    cdb_val, val);
    chk({tag, ".jump"},   {31'd0, cdb_jump}, {31'd0, jump});
    chk({tag, ".target"}, cdb_target, target);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    ready     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_NOP;
    in_imm    = '0;
    in_pc     = '0;
    in_robpos = '0;
    in_vj     = '0;
    in_vk     = '0;
    cdb_grant = 1'b0;

    step();
    step();
    chk("rst.valid",  {31'd0, cdb_valid}, 32'd0);
    chk("rst.stall",  {31'd0, alu_stall}, 32'd0);
    chk("rst.val",    cdb_val, 32'd0);
    chk("rst.target", cdb_target, 32'd0);
    chk("rst.count",  32'(dut.count), 32'd0);
    reset = 1'b1;
    step();

    // ADDI with grant held: visible one cycle after issue, gone the cycle after
    cdb_grant = 1'b1;
    issue(OP_ADDI, 32'hFFFF_FFF9, 32'h0, 4'd3, 32'd5, 32'd0);
    chk_head("addi", 32'hFFFF_FFFE, 1'b0, 32'h4);
    chk("addi.rob", 32'(cdb_robpos), 32'd3);
    step();
    chk("addi.drained", {31'd0, cdb_valid}, 32'd0);

    // signed vs unsigned branch on the same operands, back to back
    issue(OP_BLT, 32'h20, 32'h100, 4'd1, 32'hFFFF_FFFF, 32'd1);
    chk_head("blt", 32'd0, 1'b1, 32'h120);
    issue(OP_BLTU, 32'h20, 32'h100, 4'd2, 32'hFFFF_FFFF, 32'd1);
    chk_head("bltu", 32'd0, 1'b0, 32'h104);
    chk("bltu.rob", 32'(cdb_robpos), 32'd2);

    issue(OP_JALR, 32'd2, 32'h40, 4'd4, 32'h1003, 32'd0);
    chk_head("jalr", 32'h44, 1'b1, 32'h1004);

    issue(OP_JAL, 32'hFFFF_FFF8, 32'h80, 4'd5, 32'd0, 32'd0);
    chk_head("jal", 32'h84, 1'b1, 32'h78);
    issue(OP_BEQ, 32'h10, 32'h10, 4'd6, 32'd7, 32'd7);
    chk_head("beq", 32'd0, 1'b1, 32'h20);
    issue(OP_BNE, 32'h10, 32'h10, 4'd6, 32'd7, 32'd7);
    chk_head("bne", 32'd0, 1'b0, 32'h14);
    issue(OP_BGE, 32'h8, 32'h0, 4'd6, 32'hFFFF_FFFF, 32'd1);
    chk_head("bge", 32'd0, 1'b0, 32'h4);
    issue(OP_SRAI, 32'd4, 32'h0, 4'd7, 32'h8000_0000, 32'd0);
    chk_head("srai", 32'hF800_0000, 1'b0, 32'h4);
    issue(OP_SRL, 32'd0, 32'h0, 4'd7, 32'h8000_0000, 32'h24);
    chk_head("srl", 32'h0800_0000, 1'b0, 32'h4);
    issue(OP_SLTU, 32'd0, 32'h0, 4'd7, 32'd1, 32'hFFFF_FFFF);
    chk_head("sltu", 32'd1, 1'b0, 32'h4);
    issue(OP_SLT, 32'd0, 32'h0, 4'd7, 32'd1, 32'hFFFF_FFFF);
    chk_head("slt", 32'd0, 1'b0, 32'h4);
    issue(OP_LUI, 32'h1234_5000, 32'h200, 4'd8, 32'd0, 32'd0);
    chk_head("lui", 32'h1234_5000, 1'b0, 32'h204);
    issue(OP_AUIPC, 32'h2000, 32'h1000, 4'd8, 32'd0, 32'd0);
    chk_head("auipc", 32'h3000, 1'b0, 32'h1004);
    issue(OP_ANDI, 32'hFF, 32'h0, 4'd8, 32'hF0F0, 32'd0);
    chk_head("andi", 32'hF0, 1'b0, 32'h4);
    issue(6'd63, 32'h0, 32'h50, 4'd9, 32'd5, 32'd5);
    chk_head("unknown", 32'd0, 1'b0, 32'h54);
    step();
    chk("tbl.drained", {31'd0, cdb_valid}, 32'd0);

    // back-pressure: three results with no grant
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd0, 32'h0, 4'd1, 32'd1, 32'd2);
    chk("fill1.stall", {31'd0, alu_stall}, 32'd0);
    issue(OP_SUB, 32'd0, 32'h0, 4'd2, 32'd10, 32'd3);
    chk("fill2.stall", {31'd0, alu_stall}, 32'd0);
    issue(OP_SLL, 32'd0, 32'h0, 4'd4, 32'd1, 32'd4);
    chk("fill3.stall", {31'd0, alu_stall}, 32'd1);
    chk("fill3.count", 32'(dut.count), 32'd3);
    chk("fill3.rob", 32'(cdb_robpos), 32'd1);
    chk("fill3.val", cdb_val, 32'd3);
    cdb_grant = 1'b1;
    step();
    chk("drain1.stall", {31'd0, alu_stall}, 32'd0);
    chk("drain1.rob", 32'(cdb_robpos), 32'd2);
    chk("drain1.val", cdb_val, 32'd7);
    step();
    chk("drain2.rob", 32'(cdb_robpos), 32'd4);
    chk("drain2.val", cdb_val, 32'h10);
    step();
    chk("drain3.valid", {31'd0, cdb_valid}, 32'd0);

    // flush with an op presented in the same cycle
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd0, 32'h0, 4'd1, 32'd1, 32'd1);
    issue(OP_ADD, 32'd0, 32'h0, 4'd2, 32'd2, 32'd2);
    chk("preclr.count", 32'(dut.count), 32'd2);
    clear = 1'b1;
    issue(OP_ADD, 32'd0, 32'h0, 4'd3, 32'd3, 32'd3);
    clear = 1'b0;
    chk("clr.valid", {31'd0, cdb_valid}, 32'd0);
    chk("clr.count", 32'(dut.count), 32'd0);
    issue(OP_ADDI, 32'd1, 32'h0, 4'd5, 32'd1, 32'd0);
    chk_head("postclr", 32'd2, 1'b0, 32'h4);
    chk("postclr.rob", 32'(cdb_robpos), 32'd5);

    // freeze: grant and a new op both ignored while ready is low
    issue(OP_ADD, 32'd0, 32'h0, 4'd6, 32'd20, 32'd22);
    ready     = 1'b0;
    cdb_grant = 1'b1;
    issue(OP_ADD, 32'd0, 32'h0, 4'd7, 32'd9, 32'd9);
    chk("frz.rob", 32'(cdb_robpos), 32'd5);
    chk("frz.val", cdb_val, 32'd2);
    chk("frz.count", 32'(dut.count), 32'd2);
    ready = 1'b1;
    step();
    chk("thaw.rob", 32'(cdb_robpos), 32'd6);
    chk("thaw.val", cdb_val, 32'd42);

    // reset while an entry is still queued
    cdb_grant = 1'b0;
    reset     = 1'b0;
    step();
    chk("rst2.valid",  {31'd0, cdb_valid}, 32'd0);
    chk("rst2.rob",    32'(cdb_robpos), 32'd0);
    chk("rst2.val",    cdb_val, 32'd0);
    chk("rst2.jump",   {31'd0, cdb_jump}, 32'd0);
    chk("rst2.target", cdb_target, 32'd0);
    chk("rst2.stall",  {31'd0, alu_stall}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
